alu_mem_responder: RTL and testbench

ALU_MEM_RESPONDER -- requirements
Module: alu_mem_responder

---
 rtl/alu_mem_responder.sv | 121 ++++++++++++
 tb/tb_alu_mem_responder.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/alu_mem_responder.sv
// Request/response memory slave for an ALU: one outstanding read or write, fixed latencies, shared DataIO bus.
// Optional macro ALU_MEM_BOUNDS_CHECK_EN flags captures whose upper address bits are nonzero.
module alu_mem_responder #(
   parameter int DEPTH_LOG2 = 8,
   parameter int READ_LAT   = 2,
   parameter int WRITE_LAT  = 1
) (
   input  logic        Clk,
   input  logic        nReset,
   input  logic [1:0]  MemIO,
   input  logic [31:0] ALUAddr,
   inout  wire  [31:0] DataIO,
   output logic        ValidMemData,
   output logic        Busy,
   output logic        MemErr
);

   localparam int         DEPTH  = 1 << DEPTH_LOG2;
   localparam logic [3:0] RD_CNT = 4'(READ_LAT - 1);
   localparam logic [3:0] WR_CNT = 4'(WRITE_LAT - 1);

   typedef enum logic [2:0] {IDLE, RD_WAIT, WR_WAIT, ACK, HOLD} state_t;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  valid_q, valid_d;
   logic                  busy_q, busy_d;
   logic                  merr_q, merr_d;
   logic                  oe_q, oe_d;
   logic                  is_wr_q, is_wr_d;
   logic                  err_q, err_d;
   logic [DEPTH_LOG2-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  addr_oob;
   logic [31:0]           mem [DEPTH];

`ifdef ALU_MEM_BOUNDS_CHECK_EN
   assign addr_oob = |ALUAddr[31:DEPTH_LOG2];
   assign MemErr   = merr_q;
`else
   logic unused_hi;
   assign addr_oob  = 1'b0;
   assign MemErr    = 1'b0;
   assign unused_hi = ^{ALUAddr[31:DEPTH_LOG2], merr_q};
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      is_wr_d = is_wr_q;
      err_d   = err_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (MemIO == 2'b01 || MemIO == 2'b10) begin
               is_wr_d = MemIO[1];
               err_d   = addr_oob;
               addr_d  = ALUAddr[DEPTH_LOG2-1:0];
               wdata_d = DataIO;
               cnt_d   = MemIO[1] ? WR_CNT : RD_CNT;
               state_d = MemIO[1] ? WR_WAIT : RD_WAIT;
            end
         end
         RD_WAIT, WR_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = ACK;
               rdata_d = err_q ? 32'h0000_0000 : mem[addr_q];
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ACK:     state_d = HOLD;
         HOLD:    if (MemIO == 2'b00) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Outputs are registered, so they are decoded from the next state.
      valid_d = (state_d == ACK);
      busy_d  = (state_d != IDLE);
      merr_d  = (state_d == ACK) && err_d;
      oe_d    = (state_d == ACK) && !is_wr_d;
   end

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         merr_q  <= 1'b0;
         oe_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         merr_q  <= merr_d;
         oe_q    <= oe_d;
      end
   end

   always_ff @(posedge Clk) begin
      is_wr_q <= is_wr_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
   end

   // Commit on the edge leaving ACK; a reset drops state_q to IDLE first, so aborted writes never land.
   always_ff @(posedge Clk) begin
      if (state_q == ACK && is_wr_q && !err_q) mem[addr_q] <= wdata_q;
   end

   assign ValidMemData = valid_q;
   assign Busy         = busy_q;
   assign DataIO       = oe_q ? rdata_q : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_alu_mem_responder.sv
// Directed bench for alu_mem_responder: default instance plus a WRITE_LAT=3 instance for the reset-abort case.
module tb_alu_mem_responder;

   logic        Clk    = 1'b0;
   logic        nReset = 1'b1;
   logic [1:0]  MemIO  = 2'b00;
   logic [1:0]  MemIO3 = 2'b00;
   logic [31:0] ALUAddr  = 32'h0;
   logic [31:0] ALUAddr3 = 32'h0;
   logic [31:0] drv  = 32'h0;
   logic [31:0] drv3 = 32'h0;
   logic        oe  = 1'b0;
   logic        oe3 = 1'b0;
   wire  [31:0] DataIO;
   wire  [31:0] DataIO3;
   logic        valid, busy, merr;
   logic        valid3, busy3, merr3;
   int          tests = 0;
   int          fails = 0;

   assign DataIO  = oe  ? drv  : 32'hzzzz_zzzz;
   assign DataIO3 = oe3 ? drv3 : 32'hzzzz_zzzz;

   always #5 Clk = ~Clk;

   alu_mem_responder dut (
      .Clk(Clk), .nReset(nReset), .MemIO(MemIO), .ALUAddr(ALUAddr), .DataIO(DataIO),
      .ValidMemData(valid), .Busy(busy), .MemErr(merr)
   );

   alu_mem_responder #(.WRITE_LAT(3)) dut3 (
      .Clk(Clk), .nReset(nReset), .MemIO(MemIO3), .ALUAddr(ALUAddr3), .DataIO(DataIO3),
      .ValidMemData(valid3), .Busy(busy3), .MemErr(merr3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_st(input string tag, input logic v, input logic b, input logic e);
      chk({tag, ".valid"}, {31'h0, valid}, {31'h0, v});
      chk({tag, ".busy"},  {31'h0, busy},  {31'h0, b});
      chk({tag, ".err"},   {31'h0, merr},  {31'h0, e});
   endtask

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   // Write with WRITE_LAT=1; bus data and address are scrambled after capture.
   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      MemIO = 2'b10; ALUAddr = addr; drv = data; oe = 1'b1;
      tick; chk_st("wr.cap", 1'b0, 1'b1, 1'b0);
      drv = ~data; ALUAddr = addr + 32'd1;
      tick; chk_st("wr.ack", 1'b1, 1'b1, 1'b0);
      tick; chk_st("wr.hold", 1'b0, 1'b1, 1'b0);
      MemIO = 2'b00; drv = 32'h0;
      tick; chk_st("wr.idle", 1'b0, 1'b0, 1'b0);
      oe = 1'b0;
   endtask

   // Read with READ_LAT=2; address is changed during RD_WAIT, MemIO held at 01 for 'hold' extra cycles.
   task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp,
                     input logic exp_err, input int hold);
      oe = 1'b0; MemIO = 2'b01; ALUAddr = addr;
      tick; chk_st({tag, ".cap"}, 1'b0, 1'b1, 1'b0);
      ALUAddr = addr ^ 32'h3;
      tick; chk_st({tag, ".wait"}, 1'b0, 1'b1, 1'b0);
      tick; chk_st({tag, ".ack"}, 1'b1, 1'b1, exp_err);
      chk({tag, ".data"}, DataIO, exp);
      oe = 1'b1; drv = 32'h0;
      for (int i = 0; i < hold + 1; i++) begin
         tick; chk_st({tag, ".hold"}, 1'b0, 1'b1, 1'b0);
         chk({tag, ".bus_released"}, DataIO, 32'h0);
      end
      MemIO = 2'b00;
      tick; chk_st({tag, ".idle"}, 1'b0, 1'b0, 1'b0);
      oe = 1'b0;
   endtask

   initial begin
      #2 nReset = 1'b0;
      #1;
      chk_st("rst", 1'b0, 1'b0, 1'b0);
      chk("rst3.busy",  {31'h0, busy3},  32'h0);
      chk("rst3.valid", {31'h0, valid3}, 32'h0);
      tick; tick;
      nReset = 1'b1;
      tick;

      wr(32'd5, 32'hDEAD_BEEF);
      wr(32'd6, 32'h6666_6666);
      wr(32'd0, 32'hA5A5_0000);

      rd("rd5_hold", 32'd5, 32'hDEAD_BEEF, 1'b0, 3);
      rd("rd5_again", 32'd5, 32'hDEAD_BEEF, 1'b0, 0);
      rd("rd6", 32'd6, 32'h6666_6666, 1'b0, 0);
`ifdef ALU_MEM_BOUNDS_CHECK_EN
      rd("rd_oob", 32'h0000_0100, 32'h0000_0000, 1'b1, 0);
`else
      rd("rd_wrap", 32'h0000_0100, 32'hA5A5_0000, 1'b0, 0);
`endif

      // Reserved request code must be ignored.
      oe = 1'b1; drv = 32'h0; MemIO = 2'b11; ALUAddr = 32'd5;
      for (int i = 0; i < 3; i++) begin
         tick; chk_st("rsvd", 1'b0, 1'b0, 1'b0);
         chk("rsvd.bus", DataIO, 32'h0);
      end
      MemIO = 2'b00; oe = 1'b0;
      tick;

      // WRITE_LAT=3 completion timing on the second instance.
      MemIO3 = 2'b10; ALUAddr3 = 32'd7; drv3 = 32'h1111_2222; oe3 = 1'b1;
      tick; chk("w3.cap.busy", {31'h0, busy3}, 32'h1);
      drv3 = 32'h0;
      tick; chk("w3.c1.valid", {31'h0, valid3}, 32'h0);
      tick; chk("w3.c2.valid", {31'h0, valid3}, 32'h0);
      tick; chk("w3.c3.valid", {31'h0, valid3}, 32'h1);
      tick; chk("w3.hold.valid", {31'h0, valid3}, 32'h0);
      MemIO3 = 2'b00;
      tick; chk("w3.idle.busy", {31'h0, busy3}, 32'h0);

      // Abort an overwrite of address 7 mid WR_WAIT.
      MemIO3 = 2'b10; ALUAddr3 = 32'd7; drv3 = 32'h1234_5678;
      tick; tick;
      chk("w3abort.pre.busy", {31'h0, busy3}, 32'h1);
      #2 nReset = 1'b0;
      #1;
      chk("w3abort.busy",  {31'h0, busy3},  32'h0);
      chk("w3abort.valid", {31'h0, valid3}, 32'h0);
      chk("w3abort.err",   {31'h0, merr3},  32'h0);
      MemIO3 = 2'b00; oe3 = 1'b0;
      tick; tick;
      chk("w3abort.held.busy", {31'h0, busy3}, 32'h0);
      nReset = 1'b1;
      tick;

      MemIO3 = 2'b01; ALUAddr3 = 32'd7;
      tick; tick;
      chk("r3.wait.valid", {31'h0, valid3}, 32'h0);
      tick;
      chk("r3.ack.valid", {31'h0, valid3}, 32'h1);
      chk("r3.old_data", DataIO3, 32'h1111_2222);
      MemIO3 = 2'b00;
      tick; tick;
      chk("r3.idle.busy", {31'h0, busy3}, 32'h0);

      rd("rd5_after_rst", 32'd5, 32'hDEAD_BEEF, 1'b0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
